// File: rtl/tinyalu_master.sv
// Command-to-TinyALU sequencer: accepts one command, drives the ALU start/reset
// handshake, and returns the result (or a timeout abort) through a response port.
module tinyalu_master #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  op,
  output logic        start,
  output logic        alu_reset_n,
  input  logic        done,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] NOP    = 3'd2;
  localparam logic [2:0] ALURST = 3'd3;
  localparam logic [2:0] RSP    = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_reg;
  logic [7:0] cnt_reg;

  // alu_reset_n is low only in reset and ALURST, so it also masks the
  // first cycle after reset release.
  assign cmd_ready = (state_reg == IDLE) && alu_reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      A           <= 8'd0;
      B           <= 8'd0;
      op          <= 3'b000;
      start       <= 1'b0;
      alu_reset_n <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 16'h0000;
      rsp_op      <= 3'b000;
      rsp_error   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          alu_reset_n <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            A       <= cmd_a;
            B       <= cmd_b;
            op      <= cmd_op;
            cnt_reg <= 8'd0;
            case (cmd_op)
              3'b001, 3'b010, 3'b011, 3'b100: begin
                start     <= 1'b1;
                state_reg <= ISSUE;
              end
              3'b111: begin
                alu_reset_n <= 1'b0;
                state_reg   <= ALURST;
              end
              default: begin
                start     <= 1'b1;
                state_reg <= NOP;
              end
            endcase
          end
        end
        ISSUE: begin
          // done takes priority over a coincident timeout
          if (done) begin
            start      <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= result;
            rsp_op     <= op;
            rsp_error  <= 1'b0;
            state_reg  <= RSP;
          end else if (cnt_reg == CNT_LAST) begin
            start      <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= 16'h0000;
            rsp_op     <= op;
            rsp_error  <= 1'b1;
            state_reg  <= RSP;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        NOP: begin
          start     <= 1'b0;
          state_reg <= IDLE;
        end
        ALURST: begin
          if (cnt_reg == 8'd1) begin
            alu_reset_n <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          start     <= 1'b0;
          rsp_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_master.sv
// Directed bench for tinyalu_master with a behavioural TinyALU whose latency
// (start-high cycles up to and including done) is set per step.
module tb_tinyalu_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        start, alu_reset_n, done;
  logic [15:0] result;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_error;

  int   checks = 0;
  int   failures = 0;
  int   alu_lat = 2;
  logic tie_low = 1'b0;
  logic done_force = 1'b0;
  logic [7:0] scnt;

  tinyalu_master #(.TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .A(A), .B(B), .op(op), .start(start), .alu_reset_n(alu_reset_n),
    .done(done), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] o);
    case (o)
      3'b001:  alu_f = {8'h00, a} + {8'h00, b};
      3'b010:  alu_f = {8'h00, a & b};
      3'b011:  alu_f = {8'h00, a ^ b};
      3'b100:  alu_f = {8'h00, a} * {8'h00, b};
      default: alu_f = 16'h0000;
    endcase
  endfunction

  // ALU model: done in the alu_lat-th cycle that start is high
  always_ff @(posedge clk) begin
    if (!alu_reset_n || !start) scnt <= 8'd0;
    else                        scnt <= scnt + 8'd1;
  end
  assign done   = done_force | (!tie_low && start && (scnt == 8'(alu_lat - 1)));
  assign result = alu_f(A, B, op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    for (int w = 0; w < 50 && !cmd_ready; w++) step();
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = o;
    step();
    cmd_valid = 1'b0;
    $display("cmd a=%02h b=%02h op=%0d", a, b, o);
  endtask

  task automatic wait_rsp(output int sc, output bit rdy_seen);
    sc = 0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      if (start) sc++;
      if (cmd_ready) rdy_seen = 1'b1;
      step();
    end
    chk("rsp_arrive", {31'd0, rsp_valid}, 32'd1);
    $display("rsp result=%04h op=%0d err=%0d start_cycles=%0d", rsp_result, rsp_op, rsp_error, sc);
  endtask

  task automatic mon(input int n, output int sc, output int arc, output bit rv);
    sc = 0;
    arc = 0;
    rv = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (start) sc++;
      if (!alu_reset_n) arc++;
      if (rsp_valid) rv = 1'b1;
      step();
    end
  endtask

  int sc, arc;
  bit seen, rv;

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = 8'h00;
    cmd_b = 8'h00;
    cmd_op = 3'b000;
    rsp_ready = 1'b1;
    #1;
    repeat (3) step();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_alu_reset_n", {31'd0, alu_reset_n}, 32'd0);
    chk("rst_outputs", {rsp_valid, rsp_error, rsp_op, op, A, B}, 32'd0);
    chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rel_alu_reset_n", {31'd0, alu_reset_n}, 32'd1);
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // add FF+01, single-cycle ALU, cycle-accurate latency
    alu_lat = 2;
    send(8'hFF, 8'h01, 3'b001);
    chk("add_n1_start", {31'd0, start}, 32'd1);
    chk("add_regs", {13'd0, A, B, op}, {13'd0, 8'hFF, 8'h01, 3'b001});
    step();
    chk("add_n2_done", {30'd0, done, start}, 32'd3);
    step();
    chk("add_n3_rsp", {12'd0, rsp_valid, rsp_result, rsp_op, rsp_error, start},
        {12'd0, 1'b1, 16'h0100, 3'b001, 1'b0, 1'b0});
    step();
    chk("add_n4_ready", {30'd0, cmd_ready, rsp_valid}, 32'd2);

    // mul FF*FF, 3-cycle ALU
    alu_lat = 3;
    send(8'hFF, 8'hFF, 3'b100);
    wait_rsp(sc, seen);
    chk("mul_start_cycles", sc, 32'd3);
    chk("mul_ready_low", {31'd0, seen}, 32'd0);
    chk("mul_result", {13'd0, rsp_result, rsp_op}, {13'd0, 16'hFE01, 3'b100});
    step();

    // and F3&5A
    alu_lat = 2;
    send(8'hF3, 8'h5A, 3'b010);
    wait_rsp(sc, seen);
    chk("and_result", {12'd0, rsp_error, rsp_result, rsp_op}, {12'd0, 1'b0, 16'h0052, 3'b010});
    step();

    // xor under 5 cycles of backpressure with a competing command
    rsp_ready = 1'b0;
    send(8'hF0, 8'h0F, 3'b011);
    wait_rsp(sc, seen);
    cmd_valid = 1'b1;
    cmd_a = 8'h11;
    cmd_b = 8'h22;
    cmd_op = 3'b001;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {15'd0, rsp_valid, rsp_result}, {15'd0, 1'b1, 16'h00FF});
      chk("bp_no_accept", {31'd0, cmd_ready}, 32'd0);
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_regs_kept", {24'd0, A}, 32'h0000_00F0);
    rsp_ready = 1'b1;
    step();
    chk("bp_released", {31'd0, rsp_valid}, 32'd0);

    // no_op, rst_op, op 101
    send(8'h01, 8'h02, 3'b000);
    mon(5, sc, arc, rv);
    chk("nop_start_pulse", sc, 32'd1);
    chk("nop_no_rsp", {31'd0, rv}, 32'd0);
    send(8'h00, 8'h00, 3'b111);
    mon(6, sc, arc, rv);
    chk("rstop_low_cycles", arc, 32'd2);
    chk("rstop_no_start_rsp", {sc[30:0], rv}, 32'd0);
    send(8'h03, 8'h04, 3'b101);
    mon(5, sc, arc, rv);
    chk("op101_nop", {sc[30:0], rv}, 32'd2);

    // stray done while idle is ignored
    done_force = 1'b1;
    step();
    step();
    done_force = 1'b0;
    chk("stray_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    // timeout with done tied low, then a normal add
    tie_low = 1'b1;
    send(8'h12, 8'h34, 3'b001);
    wait_rsp(sc, seen);
    chk("to_start_cycles", sc, 32'd15);
    chk("to_rsp", {12'd0, rsp_error, rsp_result, rsp_op}, {12'd0, 1'b1, 16'h0000, 3'b001});
    step();
    tie_low = 1'b0;
    send(8'h03, 8'h04, 3'b001);
    wait_rsp(sc, seen);
    chk("after_to_add", {12'd0, rsp_error, rsp_result, rsp_op}, {12'd0, 1'b0, 16'h0007, 3'b001});
    step();

    // done on the same edge as the timeout
    alu_lat = 15;
    send(8'h10, 8'h20, 3'b011);
    wait_rsp(sc, seen);
    chk("coinc_cycles", sc, 32'd15);
    chk("coinc_done_wins", {15'd0, rsp_error, rsp_result}, {15'd0, 1'b0, 16'h0030});
    step();

    // reset mid-mul
    alu_lat = 3;
    send(8'h0A, 8'h0B, 3'b100);
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {28'd0, start, rsp_valid, alu_reset_n, cmd_ready}, 32'd0);
    step();
    step();
    chk("midrst_hold", {29'd0, start, rsp_valid, alu_reset_n}, 32'd0);
    reset_n = 1'b1;
    step();
    send(8'h02, 8'h03, 3'b100);
    wait_rsp(sc, seen);
    chk("midrst_recover", {12'd0, rsp_error, rsp_result, rsp_op}, {12'd0, 1'b0, 16'h0006, 3'b100});
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tinyalu_master.md
TINYALU_MASTER -- requirements
Module: tinyalu_master

Interface
REQ-001 Parameter TIMEOUT, default 15, sets the maximum number of cycles start is held without done before the operation aborts (range 4..255).
REQ-002 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  Reset, asynchronous and active-low.
REQ-004 cmd_valid  input  1  Command present.
REQ-005 cmd_ready  output  1  Block can accept a command.
REQ-006 cmd_a  input  8  Operand A.
REQ-007 cmd_b  input  8  Operand B.
REQ-008 cmd_op  input  3  Op code: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op; 101/110 treated as no_op.
REQ-009 A  output  8  ALU operand A.
REQ-010 B  output  8  ALU operand B.
REQ-011 op  output  3  ALU op code.
REQ-012 start  output  1  ALU start.
REQ-013 alu_reset_n  output  1  ALU reset, active-low.
REQ-014 done  input  1  ALU completion strobe.
REQ-015 result  input  16  ALU result, valid when done is high.
REQ-016 rsp_valid  output  1  Response present.
REQ-017 rsp_ready  input  1  Consumer accepts response.
REQ-018 rsp_result  output  16  Captured result.
REQ-019 rsp_op  output  3  Op code of the completed command.
REQ-020 rsp_error  output  1  Response is a timeout abort.

Function
REQ-021 The block SHALL implement the states IDLE, ISSUE, NOP, ALURST and RSP, with cmd_ready high only in IDLE.
REQ-022 In IDLE, on cmd_valid&&cmd_ready it SHALL register cmd_a/cmd_b/cmd_op onto A/B/op. Next state: ISSUE for 001-100, NOP for 000/101/110, ALURST for 111.
REQ-023 ISSUE: start high from the cycle after acceptance until the first edge at which done is sampled high. At that edge it SHALL capture result into rsp_result, set rsp_error=0, drop start and move to RSP.
REQ-024 ISSUE: an 8-bit wait counter SHALL start at 0 on entry and increment every cycle. If the counter reaches TIMEOUT-1 with done low, start SHALL drop, rsp_result=16'h0000, rsp_error=1, and the block SHALL move to RSP.
REQ-025 If done and the timeout coincide on the same edge, done SHALL win (rsp_error=0).
REQ-026 NOP: start high for exactly one cycle, then return to IDLE with no response generated.
REQ-027 ALURST: alu_reset_n low for exactly 2 cycles, start low, then return to IDLE with no response generated.
REQ-028 RSP: rsp_valid high, with rsp_result/rsp_op/rsp_error held stable until rsp_valid&&rsp_ready; then go to IDLE on the next cycle.
REQ-029 Start SHALL therefore be low for at least 1 cycle between consecutive ALU operations.
REQ-030 Done sampled high outside ISSUE SHALL be ignored.
REQ-031 A/B/op SHALL hold their values from acceptance until the next acceptance.
REQ-032 Latency: for a single-cycle ALU with rsp_ready held high, start SHALL rise at cycle N+1, done at N+2, rsp_valid at N+3, and cmd_ready at N+4.

Reset
REQ-033 While reset_n is low, the following SHALL hold: state IDLE, start=0, rsp_valid=0, rsp_error=0, A=B=0, op=3'b000, rsp_result=0, rsp_op=0, alu_reset_n=0, counter=0, cmd_ready=0.
REQ-034 alu_reset_n SHALL rise, and cmd_ready SHALL go high, on the first clock edge after reset_n deasserts.
REQ-035 Reset asserted mid-ISSUE or mid-RSP SHALL abort the operation immediately with no response emitted.

Verification
REQ-036 Add: A=8'hFF, B=8'h01, op=001 -> start high until done; rsp_result=16'h0100, rsp_op=001, rsp_error=0.
REQ-037 Mul: A=8'hFF, B=8'hFF, op=100 with a 3-cycle ALU -> start high for 3 cycles; rsp_result=16'hFE01; cmd_ready low throughout.
REQ-038 Backpressure: rsp_ready low for 5 cycles after an xor 8'hF0^8'h0F -> rsp_valid and rsp_result=16'h00FF stable all 5 cycles; no new command accepted.
REQ-039 No_op then rst_op -> start pulses for 1 cycle; alu_reset_n pulses low for 2 cycles; rsp_valid never asserts.
REQ-040 Timeout: done tied low, TIMEOUT=15 -> start high for 15 cycles, then rsp_error=1 and rsp_result=0; a following add completes normally.
REQ-041 Reset mid-mul -> start and rsp_valid low immediately, alu_reset_n low; after release, the first command completes correctly.
